ex_mem_stage: RTL and testbench

EX/MEM pipeline stage of the 16-bit MISC-V core, directly downstream of the ID/EX register and its ALU. Latches EX results, runs a req/ack handshake to data memory for loads and stores, and presents results to the MEM/WB path. Stalls the front of the pipe while a memory access is outstanding.

---
 rtl/ex_mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers EX results, runs the req/ack data-memory
// handshake for loads/stores and stalls upstream while an access is pending.
// Optional: define MEM_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYC cycles.
module ex_mem_stage #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RD_W        = 16,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_reg_write,
    input  logic              i_reg_store,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [RD_W-1:0]   i_rd,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              o_valid,
    output logic              o_reg_write,
    output logic              o_reg_store,
    output logic [RD_W-1:0]   o_rd,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_err
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                lat_we_q, lat_we_d;
    logic                lat_load_q, lat_load_d;
    logic                lat_reg_write_q, lat_reg_write_d;
    logic                lat_reg_store_q, lat_reg_store_d;
    logic [DATA_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [RD_W-1:0]     lat_rd_q, lat_rd_d;
    logic                valid_q, valid_d;
    logic                reg_write_q, reg_write_d;
    logic                reg_store_q, reg_store_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Next-state, latch and output-slot logic
    always_comb begin
        state_d         = state_q;
        lat_we_d        = lat_we_q;
        lat_load_d      = lat_load_q;
        lat_reg_write_d = lat_reg_write_q;
        lat_reg_store_d = lat_reg_store_q;
        lat_addr_d      = lat_addr_q;
        lat_wdata_d     = lat_wdata_q;
        lat_rd_d        = lat_rd_q;
        valid_d         = 1'b0;
        reg_write_d     = 1'b0;
        reg_store_d     = reg_store_q;
        rd_d            = rd_q;
        alu_d           = alu_q;
        mem_data_d      = mem_data_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d           = cnt_q;
        err_d           = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    if (i_mem_read || i_mem_write) begin
                        state_d         = WAIT;
                        lat_we_d        = i_mem_write;
                        // a store wins when both ops are flagged
                        lat_load_d      = i_mem_read && !i_mem_write;
                        lat_reg_write_d = i_reg_write;
                        lat_reg_store_d = i_reg_store;
                        lat_addr_d      = i_alu_result;
                        lat_wdata_d     = i_store_data;
                        lat_rd_d        = i_rd;
`ifdef MEM_TIMEOUT_EN
                        cnt_d           = '0;
`endif
                    end else begin
                        valid_d     = 1'b1;
                        reg_write_d = i_reg_write;
                        reg_store_d = i_reg_store;
                        rd_d        = i_rd;
                        alu_d       = i_alu_result;
                        mem_data_d  = '0;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    valid_d     = 1'b1;
                    reg_write_d = lat_reg_write_q;
                    reg_store_d = lat_reg_store_q;
                    rd_d        = lat_rd_q;
                    alu_d       = lat_addr_q;
                    mem_data_d  = lat_load_q ? mem_rdata : '0;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = IDLE;
                    valid_d     = 1'b1;
                    reg_store_d = lat_reg_store_q;
                    rd_d        = lat_rd_q;
                    alu_d       = lat_addr_q;
                    mem_data_d  = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            lat_we_q        <= 1'b0;
            lat_load_q      <= 1'b0;
            lat_reg_write_q <= 1'b0;
            lat_reg_store_q <= 1'b0;
            lat_addr_q      <= '0;
            lat_wdata_q     <= '0;
            lat_rd_q        <= '0;
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            reg_store_q     <= 1'b0;
            rd_q            <= '0;
            alu_q           <= '0;
            mem_data_q      <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            lat_we_q        <= lat_we_d;
            lat_load_q      <= lat_load_d;
            lat_reg_write_q <= lat_reg_write_d;
            lat_reg_store_q <= lat_reg_store_d;
            lat_addr_q      <= lat_addr_d;
            lat_wdata_q     <= lat_wdata_d;
            lat_rd_q        <= lat_rd_d;
            valid_q         <= valid_d;
            reg_write_q     <= reg_write_d;
            reg_store_q     <= reg_store_d;
            rd_q            <= rd_d;
            alu_q           <= alu_d;
            mem_data_q      <= mem_data_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= cnt_d;
            err_q           <= err_d;
`endif
        end
    end

    assign o_stall      = (state_q == WAIT);
    assign mem_req      = (state_q == WAIT);
    assign mem_we       = lat_we_q;
    assign mem_addr     = lat_addr_q;
    assign mem_wdata    = lat_wdata_q;
    assign o_valid      = valid_q;
    assign o_reg_write  = reg_write_q;
    assign o_reg_store  = reg_store_q;
    assign o_rd         = rd_q;
    assign o_alu_result = alu_q;
    assign o_mem_data   = mem_data_q;
`ifdef MEM_TIMEOUT_EN
    assign o_mem_err    = err_q;
`else
    assign o_mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_reg_write, i_reg_store, i_mem_read, i_mem_write, i_flush;
    logic [15:0] i_alu_result, i_store_data, i_rd;
    logic        o_stall, mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        o_valid, o_reg_write, o_reg_store, o_mem_err;
    logic [15:0] o_rd, o_alu_result, o_mem_data;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(16), .RD_W(16), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_reg_write(i_reg_write), .i_reg_store(i_reg_store),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_rd(i_rd),
        .i_flush(i_flush), .o_stall(o_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .o_valid(o_valid), .o_reg_write(o_reg_write), .o_reg_store(o_reg_store),
        .o_rd(o_rd), .o_alu_result(o_alu_result), .o_mem_data(o_mem_data),
        .o_mem_err(o_mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_reg_write = 0; i_reg_store = 0; i_mem_read = 0; i_mem_write = 0;
        i_flush = 0; i_alu_result = 16'hFFFF; i_store_data = 16'hFFFF; i_rd = 16'hFFFF;
    endtask

    initial begin
        reset = 1; mem_ack = 0; mem_rdata = 16'h0;
        idle_inputs();
        tick(); tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_alu", o_alu_result, 0);
        chk("rst_err", o_mem_err, 0);
        reset = 0;

        // 1: ALU op, then a back-to-back ALU op
        i_valid = 1; i_alu_result = 16'h1234; i_rd = 3; i_reg_write = 1;
        tick();
        chk("alu_valid", o_valid, 1);
        chk("alu_res", o_alu_result, 16'h1234);
        chk("alu_rd", o_rd, 3);
        chk("alu_rw", o_reg_write, 1);
        chk("alu_stall", o_stall, 0);
        chk("alu_req", mem_req, 0);
        chk("alu_mdata", o_mem_data, 0);
        i_alu_result = 16'h5678; i_rd = 4; i_reg_write = 0;
        tick();
        chk("b2b_valid", o_valid, 1);
        chk("b2b_res", o_alu_result, 16'h5678);
        chk("b2b_rw", o_reg_write, 0);

        // 2: load, ack in third request cycle
        i_mem_read = 1; i_alu_result = 16'h0040; i_rd = 5; i_reg_write = 1; i_reg_store = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("ld_req", mem_req, 1);
            chk("ld_we", mem_we, 0);
            chk("ld_addr", mem_addr, 16'h0040);
            chk("ld_stall", o_stall, 1);
            chk("ld_valid", o_valid, 0);
            if (i == 2) begin mem_ack = 1; mem_rdata = 16'hBEEF; end
            tick();
        end
        mem_ack = 0;
        chk("ld_done_valid", o_valid, 1);
        chk("ld_done_data", o_mem_data, 16'hBEEF);
        chk("ld_done_rs", o_reg_store, 1);
        chk("ld_done_rw", o_reg_write, 1);
        chk("ld_done_rd", o_rd, 5);
        chk("ld_done_stall", o_stall, 0);
        chk("ld_done_req", mem_req, 0);
        tick();
        chk("ld_pulse", o_valid, 0);

        // 3: store with zero-wait ack
        i_valid = 1; i_mem_write = 1; i_alu_result = 16'h0010; i_store_data = 16'h00AA; i_rd = 6;
        tick();
        idle_inputs();
        chk("st_req", mem_req, 1);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 16'h0010);
        chk("st_wdata", mem_wdata, 16'h00AA);
        mem_ack = 1; mem_rdata = 16'h1111;
        tick();
        mem_ack = 0;
        chk("st_done_valid", o_valid, 1);
        chk("st_done_data", o_mem_data, 0);
        chk("st_done_stall", o_stall, 0);
        chk("st_done_req", mem_req, 0);

        // both read and write set: store wins
        i_valid = 1; i_mem_read = 1; i_mem_write = 1; i_alu_result = 16'h0020; i_store_data = 16'h0055;
        tick();
        idle_inputs();
        chk("rw_we", mem_we, 1);
        chk("rw_wdata", mem_wdata, 16'h0055);
        mem_ack = 1; mem_rdata = 16'h2222;
        tick();
        chk("rw_valid", o_valid, 1);
        chk("rw_data", o_mem_data, 0);

        // ack while idle is ignored
        tick();
        mem_ack = 0;
        chk("idle_ack_valid", o_valid, 0);
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_stall", o_stall, 0);

        // 4: flush in IDLE kills a load; flush in WAIT is ignored
        i_valid = 1; i_mem_read = 1; i_alu_result = 16'h0080; i_rd = 8; i_flush = 1;
        tick();
        chk("fl_idle_req", mem_req, 0);
        chk("fl_idle_valid", o_valid, 0);
        i_flush = 0;
        tick();
        chk("fl_wait_req", mem_req, 1);
        chk("fl_wait_addr", mem_addr, 16'h0080);
        idle_inputs();
        i_flush = 1;
        tick();
        chk("fl_wait_stall", o_stall, 1);
        mem_ack = 1; mem_rdata = 16'h3C3C;
        tick();
        mem_ack = 0; i_flush = 0;
        chk("fl_done_valid", o_valid, 1);
        chk("fl_done_data", o_mem_data, 16'h3C3C);
        chk("fl_done_rd", o_rd, 8);

        // 5: reset on the second WAIT cycle abandons the load
        i_valid = 1; i_mem_read = 1; i_alu_result = 16'h00C0; i_rd = 7; i_reg_write = 1;
        tick();
        idle_inputs();
        tick();
        chk("rw2_req", mem_req, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("wrst_req", mem_req, 0);
        chk("wrst_stall", o_stall, 0);
        chk("wrst_valid", o_valid, 0);
        chk("wrst_addr", mem_addr, 0);
        chk("wrst_rd", o_rd, 0);
        chk("wrst_mdata", o_mem_data, 0);
        chk("wrst_alu", o_alu_result, 0);
        mem_ack = 1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 0;
        chk("wrst_ack_valid", o_valid, 0);
        chk("wrst_ack_data", o_mem_data, 0);

`ifdef MEM_TIMEOUT_EN
        // 6: load with no ack times out after 15 request cycles
        i_valid = 1; i_mem_read = 1; i_alu_result = 16'h0100; i_rd = 9; i_reg_write = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            chk("to_req", mem_req, 1);
            chk("to_err_low", o_mem_err, 0);
            tick();
        end
        chk("to_valid", o_valid, 1);
        chk("to_rw", o_reg_write, 0);
        chk("to_err", o_mem_err, 1);
        chk("to_data", o_mem_data, 0);
        chk("to_req_low", mem_req, 0);
        chk("to_stall", o_stall, 0);
        tick();
        chk("to_err_pulse", o_mem_err, 0);
        chk("to_valid_pulse", o_valid, 0);
`else
        chk("no_to_err", o_mem_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
